// File: rtl/serial_addsub_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
//   MAX_WIDTH : largest supported operand width
//   state_e   : sequencer FSM states (IDLE, RUN, DONE)
//   maj3      : three-input majority, i.e. full-adder carry
package serial_addsub_seq_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_fa_bit.sv
// One full-adder slice with its ripple-carry flop, shared by every bit of a serial operation.
// Ports:
//   Clk, Rst_ : clock, asynchronous active-low reset
//   a, b      : current operand bits (b is raw; it is inverted here when sub=1)
//   sub       : 0 add, 1 subtract
//   load      : start of an operation; seeds the carry with sub (the +1 of two's complement)
//   en        : consume one bit pair this cycle
//   s         : sum bit of the current pair
//   co        : carry out of the current pair (combinational)
//   c_q       : carry into the current pair (registered)
module serial_fa_bit
    import serial_addsub_seq_pkg::*;
(
    input  logic Clk,
    input  logic Rst_,
    input  logic a,
    input  logic b,
    input  logic sub,
    input  logic load,
    input  logic en,
    output logic s,
    output logic co,
    output logic c_q
);

    logic b_eff;

    assign b_eff = b ^ sub;
    assign s     = a ^ b_eff ^ c_q;
    assign co    = maj3(a, b_eff, c_q);

    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            c_q <= 1'b0;
        end else if (load) begin
            c_q <= sub;
        end else if (en) begin
            c_q <= co;
        end
    end

endmodule

// File: rtl/serial_addsub_seq.sv
// Bit-serial add/subtract sequencer feeding the XOR3 domino sum cell.
// Latches two WIDTH-bit operands plus a sub flag, walks them LSB-first one bit per clock,
// and publishes result, carry-out and signed overflow together with a one-cycle done pulse.
// Ports:
//   Clk, Rst_      : clock, asynchronous active-low reset
//   start          : request an operation (ignored while busy)
//   sub            : 0 a+b, 1 a-b; sampled with start
//   a_in, b_in     : operands; sampled with start
//   busy           : high during the WIDTH bit-processing cycles
//   done           : one-cycle pulse; result/cout/ovf valid from this cycle on
//   result         : two's complement sum/difference
//   cout           : final carry (for subtract, 1 means no borrow)
//   ovf            : signed overflow
//   cell_a/b/sub   : registered bit pair and sub flag driven to the sum cell while running
// WIDTH must lie in 1..MAX_WIDTH.
module serial_addsub_seq
    import serial_addsub_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_sub
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e            state_q;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [WIDTH-1:0]  sum_sh;
    logic              sub_q;
    logic [CntW-1:0]   cnt;

    logic              run;
    logic              accept;
    logic              last_bit;
    logic              fa_s;
    logic              fa_co;
    logic              fa_c_q;
    logic [WIDTH-1:0]  a_nxt;
    logic [WIDTH-1:0]  b_nxt;
    logic [WIDTH-1:0]  sum_nxt;

    assign run      = (state_q == ST_RUN);
    assign accept   = start && !run;
    assign last_bit = run && (cnt == CntW'(WIDTH - 1));

    assign a_nxt = a_sh >> 1;
    assign b_nxt = b_sh >> 1;

    // New sum bit enters at the MSB, so after WIDTH shifts bit 0 lands at the LSB.
    always_comb begin
        sum_nxt            = sum_sh >> 1;
        sum_nxt[WIDTH-1]   = fa_s;
    end

    serial_fa_bit u_fa (
        .Clk  (Clk),
        .Rst_ (Rst_),
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .sub  (accept ? sub : sub_q),
        .load (accept),
        .en   (run),
        .s    (fa_s),
        .co   (fa_co),
        .c_q  (fa_c_q)
    );

    always_ff @(posedge Clk or negedge Rst_) begin
        if (!Rst_) begin
            state_q  <= ST_IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sh   <= '0;
            sub_q    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
            cell_a   <= 1'b0;
            cell_b   <= 1'b0;
            cell_sub <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q  <= ST_RUN;
                        a_sh     <= a_in;
                        b_sh     <= b_in;
                        sub_q    <= sub;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        cell_a   <= a_in[0];
                        cell_b   <= b_in[0];
                        cell_sub <= sub;
                    end else begin
                        state_q  <= ST_IDLE;
                        busy     <= 1'b0;
                        cell_a   <= 1'b0;
                        cell_b   <= 1'b0;
                        cell_sub <= 1'b0;
                    end
                end
                ST_RUN: begin
                    a_sh   <= a_nxt;
                    b_sh   <= b_nxt;
                    sum_sh <= sum_nxt;
                    cnt    <= cnt + CntW'(1);
                    if (last_bit) begin
                        // Publish on the final bit edge so everything is valid in the done cycle.
                        state_q  <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        result   <= sum_nxt;
                        cout     <= fa_co;
                        ovf      <= fa_c_q ^ fa_co;
                        cell_a   <= 1'b0;
                        cell_b   <= 1'b0;
                        cell_sub <= 1'b0;
                    end else begin
                        cell_a <= a_nxt[0];
                        cell_b <= b_nxt[0];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub_seq.sv
module tb_serial_addsub_seq;

    logic       Clk;
    logic       Rst_;
    logic       start;
    logic       sub;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       cout;
    logic       ovf;
    logic       cell_a;
    logic       cell_b;
    logic       cell_sub;

    int checks = 0;
    int errors = 0;

    serial_addsub_seq #(.WIDTH(8)) dut (
        .Clk      (Clk),
        .Rst_     (Rst_),
        .start    (start),
        .sub      (sub),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .ovf      (ovf),
        .cell_a   (cell_a),
        .cell_b   (cell_b),
        .cell_sub (cell_sub)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Arithmetic reference: a - b is a + ~b + 1; overflow from operand/result signs.
    function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                  output logic [7:0] r, output logic c, output logic v);
        logic [8:0] t;
        logic [7:0] bb;
        bb = s ? ~b : b;
        t  = {1'b0, a} + {1'b0, bb} + {8'd0, s};
        r  = t[7:0];
        c  = t[8];
        if (!s) v = (a[7] == b[7]) && (r[7] != a[7]);
        else    v = (a[7] != b[7]) && (r[7] != a[7]);
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s);
        a_in  = a;
        b_in  = b;
        sub   = s;
        start = 1'b1;
    endtask

    // Clears start after the accepting edge and scrambles the operand inputs,
    // then counts edges until done (bounded).
    task automatic wait_done(output int cycles, output bit timed_out);
        cycles    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            start = 1'b0;
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            sub   = 1'($urandom);
            cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({busy, done, result, cout, ovf, cell_a, cell_b, cell_sub} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {busy, done, result, cout, ovf, cell_a, cell_b, cell_sub});
        end
        Rst_ = 1'b1;
        step();
        checks++;
        if ({busy, done, result} !== 10'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %h want 0", {busy, done, result});
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [6];
        logic [7:0] tb [6];
        logic       ts [6];
        logic [7:0] tr [6];
        logic       tc [6];
        logic       tv [6];
        int         cyc;
        bit         to;
        ta = '{8'h3C, 8'h05, 8'h7F, 8'h80, 8'hFF, 8'h00};
        tb = '{8'h05, 8'h07, 8'h01, 8'h01, 8'h01, 8'h00};
        ts = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1};
        tr = '{8'h41, 8'hFE, 8'h80, 8'h7F, 8'h00, 8'h00};
        tc = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1};
        tv = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0};
        for (int i = 0; i < 6; i++) begin
            start_op(ta[i], tb[i], ts[i]);
            wait_done(cyc, to);
            checks++;
            if (to || cyc != 9) begin
                errors++;
                $display("FAIL directed_latency[%0d] got %0d want 9", i, cyc);
            end
            checks++;
            if ({result, cout, ovf} !== {tr[i], tc[i], tv[i]}) begin
                errors++;
                $display("FAIL directed_result[%0d] got %h/%b/%b want %h/%b/%b",
                         i, result, cout, ovf, tr[i], tc[i], tv[i]);
            end
            step();
        end
    endtask

    task automatic test_cells(input logic [7:0] a, input logic [7:0] b, input logic s);
        int bad;
        bad = 0;
        start_op(a, b, s);
        for (int i = 0; i < 8; i++) begin
            step();
            start = 1'b0;
            if (busy !== 1'b1 || cell_a !== a[i] || cell_b !== b[i] || cell_sub !== s) begin
                bad++;
                $display("FAIL cell_bit[%0d] got busy=%b a=%b b=%b sub=%b want 1 %b %b %b",
                         i, busy, cell_a, cell_b, cell_sub, a[i], b[i], s);
            end
        end
        checks++;
        if (bad != 0) errors++;
        step();
        checks++;
        if (done !== 1'b1 || {busy, cell_a, cell_b, cell_sub} !== 4'd0) begin
            errors++;
            $display("FAIL cell_idle_at_done got done=%b busy/cells=%b want 1 0000",
                     done, {busy, cell_a, cell_b, cell_sub});
        end
        step();
    endtask

    task automatic test_ignore_and_back_to_back();
        int  cyc;
        bit  to;
        bit  seen;
        start_op(8'h10, 8'h20, 1'b0);
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            start = (cyc == 3);
            a_in  = (cyc == 3) ? 8'hAA : 8'h00;
            b_in  = 8'h00;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!seen || cyc != 9) begin
            errors++;
            $display("FAIL ignore_latency got %0d want 9", cyc);
        end
        checks++;
        if (result !== 8'h30) begin
            errors++;
            $display("FAIL ignore_result got %h want 30", result);
        end
        // Start issued in the done cycle itself.
        start_op(8'h01, 8'h01, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || cyc != 9) begin
            errors++;
            $display("FAIL b2b_latency got %0d want 9", cyc);
        end
        checks++;
        if (result !== 8'h02) begin
            errors++;
            $display("FAIL b2b_result got %h want 02", result);
        end
        step();
        checks++;
        if (done !== 1'b0 || result !== 8'h02) begin
            errors++;
            $display("FAIL done_pulse_hold got done=%b result=%h want 0 02", done, result);
        end
    endtask

    task automatic test_abort();
        int cyc;
        bit to;
        int bad;
        start_op(8'h55, 8'h11, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
        end
        Rst_ = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, cout, ovf, cell_a, cell_b, cell_sub} !== 14'd0) begin
            errors++;
            $display("FAIL abort_outputs got %h want 0",
                     {busy, done, result, cout, ovf, cell_a, cell_b, cell_sub});
        end
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (i == 2) Rst_ = 1'b1;
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d bad cycles want 0", bad);
        end
        start_op(8'h12, 8'h34, 1'b0);
        wait_done(cyc, to);
        checks++;
        if (to || result !== 8'h46 || cyc != 9) begin
            errors++;
            $display("FAIL after_abort got %h in %0d cycles want 46 in 9", result, cyc);
        end
        step();
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic       s;
        logic [7:0] er;
        logic       ec;
        logic       ev;
        int         cyc;
        bit         to;
        int         gap;
        for (int n = 0; n < 30; n++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            s = 1'($urandom);
            model(a, b, s, er, ec, ev);
            start_op(a, b, s);
            wait_done(cyc, to);
            checks++;
            if (to || cyc != 9 || {result, cout, ovf} !== {er, ec, ev}) begin
                errors++;
                $display("FAIL random[%0d] %h%s%h got %h/%b/%b cyc %0d want %h/%b/%b cyc 9",
                         n, a, s ? "-" : "+", b, result, cout, ovf, cyc, er, ec, ev);
            end
            // Sometimes idle a while and confirm the outputs hold; otherwise go back-to-back.
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                checks++;
                if (done !== 1'b0 || {result, cout, ovf} !== {er, ec, ev}) begin
                    errors++;
                    $display("FAIL random_hold[%0d] got %b %h/%b/%b want 0 %h/%b/%b",
                             n, done, result, cout, ovf, er, ec, ev);
                end
            end
        end
    endtask

    initial begin
        Rst_  = 1'b0;
        start = 1'b0;
        sub   = 1'b0;
        a_in  = '0;
        b_in  = '0;
        repeat (3) step();
        test_reset();
        test_directed();
        test_cells(8'hFF, 8'h01, 1'b0);
        test_cells(8'hA6, 8'h3B, 1'b1);
        test_ignore_and_back_to_back();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
